// File: rtl/master_pkg.sv
// Shared bus package: FSM state encoding and default bus widths
// used by the master and the slave memory.
package master_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 32;
  localparam int LEN_W  = 4;

  typedef enum logic [1:0] {
    IDLE,
    WRITE,
    READ,
    DONE
  } state_t;

endpackage

// File: rtl/rd_skid_reg.sv
// Read-data output register: loads a new beat, holds it under
// backpressure, drops valid once the beat is consumed.
module rd_skid_reg #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  load,
  input  logic                  ready,
  input  logic                  last_in,
  input  logic [DATA_WIDTH-1:0] din,
  output logic                  valid,
  output logic                  last,
  output logic [DATA_WIDTH-1:0] data
);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      valid <= 1'b0;
      last  <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      last  <= last_in;
      data  <= din;
    end else if (ready) begin
      valid <= 1'b0;
      last  <= 1'b0;
    end
  end

endmodule

// File: rtl/master.sv
// Burst bus master: accepts a command, streams write data to the
// slave memory or streams read data back with one-beat latency.
module master
  import master_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W,
  parameter int DATA_WIDTH = DATA_W,
  parameter int LEN_WIDTH  = LEN_W
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [LEN_WIDTH-1:0]  req_len,
  input  logic                  wd_valid,
  output logic                  wd_ready,
  input  logic [DATA_WIDTH-1:0] wd_data,
  output logic                  rd_valid,
  input  logic                  rd_ready,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_last,
  output logic                  done,
  output logic                  wen,
  output logic                  ren,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  state_t                state;
  logic [ADDR_WIDTH-1:0] base;
  logic [LEN_WIDTH-1:0]  len;
  logic [LEN_WIDTH:0]    cnt;
  logic                  last_cnt;
  logic                  wd_hs;
  logic                  rd_fire;
  logic                  rd_end;
  logic                  in_xfer;

  // cnt is the beat index in WRITE and the issued count in READ
  assign last_cnt = (cnt == {1'b0, len});
  assign in_xfer  = (state == WRITE) || (state == READ);
  assign wd_hs    = (state == WRITE) && wd_valid;
  assign rd_fire  = (state == READ) && (cnt <= {1'b0, len})
                 && (!rd_valid || rd_ready);
  assign rd_end   = rd_valid && rd_ready && rd_last;

  assign req_ready = (state == IDLE);
  assign wd_ready  = (state == WRITE);
  // gate strobes with rstn so a reset cycle never touches memory
  assign wen   = rstn && wd_hs;
  assign ren   = rstn && rd_fire;
  assign addr  = in_xfer ? base + ADDR_WIDTH'(cnt) : '0;
  assign wdata = (state == WRITE) ? wd_data : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state <= IDLE;
      base  <= '0;
      len   <= '0;
      cnt   <= '0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            base  <= req_addr;
            len   <= req_len;
            cnt   <= '0;
            state <= req_write ? WRITE : READ;
          end
        end
        WRITE: begin
          if (wd_valid) begin
            cnt <= cnt + 1'b1;
            if (last_cnt) begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_fire) cnt <= cnt + 1'b1;
          if (rd_end) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  rd_skid_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rd_skid (
    .clk    (clk),
    .rstn   (rstn),
    .load   (rd_fire),
    .ready  (rd_ready),
    .last_in(last_cnt),
    .din    (rdata),
    .valid  (rd_valid),
    .last   (rd_last),
    .data   (rd_data)
  );

endmodule

// File: tb/tb_master.sv
// Directed bench for master with a behavioural slave memory.
// Expected values are hand-derived constants per vector.
module tb_master;

  localparam int AW = 16;
  localparam int DW = 32;
  localparam int LW = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic          wd_valid, wd_ready;
  logic [DW-1:0] wd_data;
  logic          rd_valid, rd_ready, rd_last;
  logic [DW-1:0] rd_data;
  logic          done, wen, ren;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata, rdata;

  logic [DW-1:0] mem [0:(1<<AW)-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  master #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .LEN_WIDTH (LW)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_write(req_write),
    .req_addr (req_addr),
    .req_len  (req_len),
    .wd_valid (wd_valid),
    .wd_ready (wd_ready),
    .wd_data  (wd_data),
    .rd_valid (rd_valid),
    .rd_ready (rd_ready),
    .rd_data  (rd_data),
    .rd_last  (rd_last),
    .done     (done),
    .wen      (wen),
    .ren      (ren),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata)
  );

  always @(posedge clk) if (wen) mem[addr] <= wdata;
  assign rdata = mem[addr];

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic send(input logic w, input logic [15:0] a, input int l);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_len   = 4'(l);
    #1;
    chk("req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic finish_chk(input string tag);
    @(negedge clk);
    req_valid = 1'b0;
    wd_valid  = 1'b0;
    rd_ready  = 1'b1;
    #1;
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_strobe"}, 32'({wen, ren}), 32'd0);
    chk({tag, "_rdv"}, 32'(rd_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({tag, "_done_off"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(req_ready), 32'd1);
  endtask

  task automatic wr_burst(input logic [15:0] a, input int l,
                          input logic [15:0] pat, input int npat,
                          input logic [31:0] d0);
    int beat;
    logic [15:0] ea;
    beat = 0;
    send(1'b1, a, l);
    for (int i = 0; i < npat && beat <= l; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      wd_valid  = pat[i];
      wd_data   = d0 + 32'(beat);
      #1;
      chk("wd_ready", 32'(wd_ready), 32'd1);
      chk("wen", 32'(wen), 32'(pat[i]));
      chk("ren_in_wr", 32'(ren), 32'd0);
      if (pat[i]) begin
        ea = a + 16'(beat);
        chk("waddr", 32'(addr), 32'(ea));
        chk("wdata", wdata, d0 + 32'(beat));
        beat++;
      end
    end
    chk("wr_beats", 32'(beat), 32'(l + 1));
    finish_chk("wr");
  endtask

  task automatic rd_burst(input logic [15:0] a, input int l,
                          input logic [15:0] rmask, input logic [31:0] d0);
    int k, issued, stalls, cyc, first;
    logic [15:0] ea;
    k = 0; issued = 0; stalls = 0; cyc = 0; first = -1;
    send(1'b0, a, l);
    while (k <= l && cyc < 40) begin
      @(negedge clk);
      req_valid = 1'b0;
      rd_ready  = (cyc < 16) ? rmask[cyc] : 1'b1;
      #1;
      chk("wen_in_rd", 32'(wen), 32'd0);
      if (ren) begin
        ea = a + 16'(issued);
        chk("raddr", 32'(addr), 32'(ea));
        issued++;
      end
      if (rd_valid) begin
        if (first < 0) first = cyc;
        chk("rdata", rd_data, d0 + 32'(k));
        chk("rlast", 32'(rd_last), 32'(k == l));
        if (rd_ready) k++;
        else begin
          stalls++;
          chk("ren_stall", 32'(ren), 32'd0);
        end
      end
      cyc++;
    end
    chk("rd_beats", 32'(k), 32'(l + 1));
    chk("rd_issued", 32'(issued), 32'(l + 1));
    chk("rd_span", 32'(cyc - first), 32'(l + 1 + stalls));
    finish_chk("rd");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    int k;
    logic hit;
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    rstn = 1'b0; req_valid = 1'b0; req_write = 1'b0;
    req_addr = '0; req_len = '0; wd_valid = 1'b0;
    wd_data = '0; rd_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_rdv", 32'(rd_valid), 32'd0);
    chk("rst_rlast", 32'(rd_last), 32'd0);
    chk("rst_rdata", rd_data, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_strobe", 32'({wen, ren}), 32'd0);
    chk("rst_addr", 32'(addr), 32'd0);
    chk("rst_wdata", wdata, 32'd0);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'd1);

    // wd_valid in IDLE must be ignored
    @(negedge clk);
    wd_valid = 1'b1;
    #1;
    chk("idle_wd_ready", 32'(wd_ready), 32'd0);
    chk("idle_wen", 32'(wen), 32'd0);
    @(negedge clk);
    wd_valid = 1'b0;
    #1;
    chk("idle_stay", 32'(req_ready), 32'd1);

    wr_burst(16'h0010, 0, 16'h0001, 1, 32'hDEADBEEF);
    chk("mem_10", mem[16'h0010], 32'hDEADBEEF);

    wr_burst(16'h0020, 3, 16'h001D, 5, 32'hA000_0000);
    chk("mem_23", mem[16'h0023], 32'hA000_0003);

    rd_burst(16'h0020, 3, 16'hFFFF, 32'hA000_0000);
    rd_burst(16'h0020, 3, 16'hFFE3, 32'hA000_0000);
    rd_burst(16'h0010, 0, 16'hFFFF, 32'hDEADBEEF);

    wr_burst(16'hFFFE, 3, 16'hFFFF, 4, 32'h5000_0000);
    chk("wrap_fffe", mem[16'hFFFE], 32'h5000_0000);
    chk("wrap_ffff", mem[16'hFFFF], 32'h5000_0001);
    chk("wrap_0000", mem[16'h0000], 32'h5000_0002);
    chk("wrap_0001", mem[16'h0001], 32'h5000_0003);

    // reset while beat 2 of a len=7 read is presented
    send(1'b0, 16'h0020, 7);
    k = 0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge clk);
      req_valid = 1'b0;
      rd_ready  = 1'b1;
      #1;
      if (rd_valid && k == 2) begin
        rstn = 1'b0;
        hit  = 1'b1;
        #1;
        chk("ren_in_rst", 32'(ren), 32'd0);
      end else if (rd_valid) k++;
    end
    chk("rst_hit", 32'(hit), 32'd1);
    @(negedge clk);
    #1;
    chk("mid_rst_ren", 32'(ren), 32'd0);
    chk("mid_rst_rdv", 32'(rd_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_idle", 32'(req_ready), 32'd1);
    rstn = 1'b1;
    @(negedge clk);
    #1;
    chk("rel_ready", 32'(req_ready), 32'd1);
    chk("rel_rdv", 32'(rd_valid), 32'd0);
    chk("rel_ren", 32'(ren), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
